// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution datapath.
// Define ROUND_QUANT_EN for round-to-nearest, saturating pixel quantisation.
package conv_pkg;

  localparam int PIX_W = 8;
  localparam int Q_W   = 4;
  localparam int WIN_N = 9;

  typedef logic [WIN_N-1:0][Q_W-1:0] win_t;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  function automatic logic [Q_W-1:0] quantize(input logic [PIX_W-1:0] pix);
`ifdef ROUND_QUANT_EN
    logic [PIX_W:0] sum;
    // A carry out of the rounding add means the result would be 16, so clamp to 15
    sum = {1'b0, pix} + 9'd8;
    quantize = sum[PIX_W] ? {Q_W{1'b1}} : sum[PIX_W-1:PIX_W-Q_W];
`else
    quantize = pix[PIX_W-1:PIX_W-Q_W];
`endif
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-row delay line: dout is the sample pushed DEPTH enables ago.
module conv_line_buffer import conv_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [Q_W-1:0] din,
  output logic [Q_W-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [Q_W-1:0] mem [DEPTH];
  logic [AW-1:0]  ptr;

  // Read-before-write at the same slot gives exactly DEPTH stages of delay
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else if (en) ptr <= (ptr == AW'(DEPTH-1)) ? '0 : ptr + AW'(1);
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Streams raster pixels into 3x3 windows of quantised pixels for the convolution.
// Define ROUND_QUANT_EN (see conv_pkg) to select rounding quantisation.
module conv_window_feeder import conv_pkg::*; #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PIX_W-1:0]            pix_in,
  input  logic                        pix_valid,
  input  logic                        sof,
  output logic                        pix_ready,
  output logic [WIN_N-1:0][Q_W-1:0]   win_out,
  output logic                        win_valid,
  input  logic                        win_ready
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  state_t                 state, state_nxt;
  logic [CW-1:0]          col, cur_col;
  logic [RW-1:0]          row, cur_row;
  logic                   accept, frame_pix, load, last_col;
  logic [Q_W-1:0]         q, above1, above2;
  logic [2:0][Q_W-1:0]    newcol;
  logic [2:0][1:0][Q_W-1:0] sr;
  win_t                   win_nxt;

  assign pix_ready = (state != DONE) && (!win_valid || win_ready);
  assign accept    = pix_valid && pix_ready;
  // Pixels accepted in IDLE without sof are discarded and never enter the frame
  assign frame_pix = accept && (sof || state != IDLE);
  assign cur_col   = sof ? '0 : col;
  assign cur_row   = sof ? '0 : row;
  assign last_col  = (cur_col == CW'(IMG_W-1));
  assign load      = frame_pix && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  assign q         = quantize(pix_in);
  assign newcol    = {q, above1, above2};

  conv_line_buffer #(.DEPTH(IMG_W)) u_lb_r1 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (frame_pix),
    .din  (q),
    .dout (above1)
  );

  conv_line_buffer #(.DEPTH(IMG_W)) u_lb_r2 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (frame_pix),
    .din  (above1),
    .dout (above2)
  );

  // Window = two previously shifted columns plus the column arriving now
  always_comb begin
    win_nxt = '0;
    for (int i = 0; i < 3; i++) begin
      win_nxt[3*i]   = sr[i][0];
      win_nxt[3*i+1] = sr[i][1];
      win_nxt[3*i+2] = newcol[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (frame_pix) begin
      for (int i = 0; i < 3; i++) begin
        sr[i][0] <= sr[i][1];
        sr[i][1] <= newcol[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (frame_pix) begin
      col <= last_col ? '0 : cur_col + CW'(1);
      if (last_col) row <= (cur_row == RW'(IMG_H-1)) ? '0 : cur_row + RW'(1);
      else          row <= cur_row;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_out   <= '0;
      win_valid <= 1'b0;
    end else if (load) begin
      win_out   <= win_nxt;
      win_valid <= 1'b1;
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && sof) state_nxt = FILL;
      end
      FILL: begin
        if (frame_pix && (sof || (cur_row == RW'(2) && cur_col == '0)))
          state_nxt = sof ? FILL : STREAM;
      end
      STREAM: begin
        if (frame_pix && sof)
          state_nxt = FILL;
        else if (frame_pix && cur_row == RW'(IMG_H-1) && last_col)
          state_nxt = DONE;
      end
      DONE: begin
        if (!win_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench: a 4x4 and a 16x16 conv_window_feeder driven by one
// directed sequence, every delivered window checked against a scoreboard.
`timescale 1ns/1ps
module tb_conv_window_feeder;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] pix_in;
  logic sof;
  logic pix_valid4, pix_valid16;
  logic win_ready = 1'b1;
  logic pix_ready4, pix_ready16, win_valid4, win_valid16;
  logic [8:0][3:0] win_out4, win_out16;

  int nChecks = 0;
  int nFails = 0;
  bit randReady = 1'b0;
  bit fixedReady = 1'b1;
  bit gapEn = 1'b0;
  logic [35:0] sb4[$];
  logic [35:0] sb16[$];
  int winCnt[2];
  logic [35:0] firstWin[2];
  logic [35:0] lastWin[2];
  bit capFirst[2];
  int mr[2];
  int mc[2];
  logic [3:0] img[2][16][16];

  localparam logic [35:0] FIRST4 = {4'd10, 4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd2, 4'd1, 4'd0};
  localparam logic [35:0] LAST4  = {4'd15, 4'd14, 4'd13, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5};
`ifdef ROUND_QUANT_EN
  localparam logic [3:0] Q_F8 = 4'd15;
  localparam logic [3:0] Q_18 = 4'd2;
`else
  localparam logic [3:0] Q_F8 = 4'd15;
  localparam logic [3:0] Q_18 = 4'd1;
`endif

  always #5 clk = ~clk;

  conv_window_feeder #(.IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid4), .sof(sof),
    .pix_ready(pix_ready4), .win_out(win_out4), .win_valid(win_valid4), .win_ready(win_ready)
  );

  conv_window_feeder #(.IMG_W(16), .IMG_H(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid16), .sof(sof),
    .pix_ready(pix_ready16), .win_out(win_out16), .win_valid(win_valid16), .win_ready(win_ready)
  );

  function automatic logic [3:0] quantModel(input logic [7:0] p);
`ifdef ROUND_QUANT_EN
    int v;
    v = (int'(p) + 8) / 16;
    return (v > 15) ? 4'd15 : 4'(v);
`else
    return p[7:4];
`endif
  endfunction

  function automatic logic getReady(input int b);
    return (b == 0) ? pix_ready4 : pix_ready16;
  endfunction

  function automatic state_t getState(input int b);
    return (b == 0) ? dut4.state : dut16.state;
  endfunction

  task automatic checkOutput(input string tag, input logic [35:0] obs, input logic [35:0] expv);
    nChecks++;
    assert (obs === expv) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Consumer side: win_ready only moves 2ns after posedge, so negedge sees the handshake
  always @(posedge clk) begin
    #2;
    win_ready = randReady ? 1'($urandom_range(0, 1)) : fixedReady;
  end

  task automatic consume(input int b, input logic [35:0] w);
    logic [35:0] e;
    int sz;
    sz = (b == 0) ? sb4.size() : sb16.size();
    checkOutput("sb_has_entry", 36'(sz > 0), 36'd1);
    if (sz > 0) begin
      if (b == 0) e = sb4.pop_front();
      else        e = sb16.pop_front();
      checkOutput((b == 0) ? "window4" : "window16", w, e);
    end
    if (capFirst[b]) begin
      firstWin[b] = w;
      capFirst[b] = 1'b0;
    end
    lastWin[b] = w;
    winCnt[b]++;
  endtask

  always @(negedge clk) begin
    if (win_valid4 && win_ready)  consume(0, win_out4);
    if (win_valid16 && win_ready) consume(1, win_out16);
  end

  task automatic applyStimulus(input int b, input logic [7:0] p, input bit s);
    int n;
    n = 0;
    if (gapEn) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    pix_in = p;
    sof = s;
    if (b == 0) pix_valid4 = 1'b1; else pix_valid16 = 1'b1;
    @(negedge clk);
    while (!getReady(b) && n < 200) begin @(negedge clk); n++; end
    if (!getReady(b)) checkOutput("pix_ready_timeout", 36'(getReady(b)), 36'd1);
    @(posedge clk); #1;
    pix_valid4 = 1'b0;
    pix_valid16 = 1'b0;
    sof = 1'b0;
  endtask

  // Reference model of frame position; queues the window each pixel should complete
  task automatic framePixel(input int b, input logic [7:0] p, input bit s);
    int w;
    logic [35:0] expWin;
    w = (b == 0) ? 4 : 16;
    if (s) begin mr[b] = 0; mc[b] = 0; end
    img[b][mr[b]][mc[b]] = quantModel(p);
    applyStimulus(b, p, s);
    if (mr[b] >= 2 && mc[b] >= 2) begin
      for (int k = 0; k < 9; k++) expWin[4*k +: 4] = img[b][mr[b]-2+k/3][mc[b]-2+k%3];
      if (b == 0) sb4.push_back(expWin); else sb16.push_back(expWin);
    end
    if (mc[b] == w-1) begin
      mc[b] = 0;
      mr[b] = (mr[b] == w-1) ? 0 : mr[b] + 1;
    end else begin
      mc[b]++;
    end
  endtask

  task automatic sendFrame(input int b, input int mode);
    int w;
    logic [7:0] p;
    w = (b == 0) ? 4 : 16;
    winCnt[b] = 0;
    capFirst[b] = 1'b1;
    for (int r = 0; r < w; r++) begin
      for (int c = 0; c < w; c++) begin
        case (mode)
          0:       p = 8'((r*w + c) << 4);
          1:       p = ((r*w + c) % 2 == 0) ? 8'hF8 : 8'h18;
          default: p = 8'($urandom_range(0, 255));
        endcase
        framePixel(b, p, (r == 0 && c == 0));
      end
    end
    checkOutput("state_done", 36'(getState(b)), 36'(DONE));
  endtask

  task automatic waitIdle(input int b);
    int n;
    n = 0;
    while (getState(b) != IDLE && n < 1000) begin @(negedge clk); n++; end
    checkOutput("state_idle", 36'(getState(b)), 36'(IDLE));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [35:0] held;
    int n;
    rst_n = 1'b0;
    pix_in = '0;
    sof = 1'b0;
    pix_valid4 = 1'b0;
    pix_valid16 = 1'b0;
    #12;
    checkOutput("rst_win_valid4", 36'(win_valid4), 36'd0);
    checkOutput("rst_win_out4", win_out4, 36'd0);
    checkOutput("rst_pix_ready4", 36'(pix_ready4), 36'd1);
    checkOutput("rst_state16", 36'(dut16.state), 36'(IDLE));
    checkOutput("rst_rowcol16", 36'({dut16.row, dut16.col}), 36'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", 36'(pix_ready16), 36'd1);

    $display("[TB] 4x4 ramp frame, win_ready high");
    sendFrame(0, 0);
    waitIdle(0);
    checkOutput("count4_a", 36'(winCnt[0]), 36'd4);
    checkOutput("first4_a", firstWin[0], FIRST4);
    checkOutput("last4_a", lastWin[0], LAST4);
    checkOutput("sb4_empty_a", 36'(sb4.size()), 36'd0);

    $display("[TB] 4x4 ramp frame with backpressure on first window");
    fixedReady = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    fork
      sendFrame(0, 0);
      begin
        n = 0;
        while (!win_valid4 && n < 200) begin @(negedge clk); n++; end
        checkOutput("hold_win_valid", 36'(win_valid4), 36'd1);
        held = win_out4;
        repeat (5) begin
          @(negedge clk);
          checkOutput("hold_stable", win_out4, held);
          checkOutput("hold_pix_ready", 36'(pix_ready4), 36'd0);
        end
        fixedReady = 1'b1;
      end
    join
    waitIdle(0);
    checkOutput("count4_b", 36'(winCnt[0]), 36'd4);
    checkOutput("first4_b", firstWin[0], FIRST4);
    checkOutput("last4_b", lastWin[0], LAST4);
    checkOutput("sb4_empty_b", 36'(sb4.size()), 36'd0);

    $display("[TB] 4x4 quantisation frame");
    sendFrame(0, 1);
    waitIdle(0);
    checkOutput("count4_q", 36'(winCnt[0]), 36'd4);
    checkOutput("quant_f8", 36'(firstWin[0][3:0]), 36'(Q_F8));
    checkOutput("quant_18", 36'(firstWin[0][7:4]), 36'(Q_18));

    $display("[TB] 16x16 random frame, random valid/ready");
    randReady = 1'b1;
    gapEn = 1'b1;
    sendFrame(1, 2);
    waitIdle(1);
    randReady = 1'b0;
    gapEn = 1'b0;
    checkOutput("count16", 36'(winCnt[1]), 36'd196);
    checkOutput("sb16_empty", 36'(sb16.size()), 36'd0);
    winCnt[1] = 0;
    for (int k = 0; k < 10; k++) applyStimulus(1, 8'($urandom_range(0, 255)), 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("discard_state", 36'(dut16.state), 36'(IDLE));
    checkOutput("discard_rowcol", 36'({dut16.row, dut16.col}), 36'd0);
    checkOutput("discard_count", 36'(winCnt[1]), 36'd0);
    checkOutput("discard_win_valid", 36'(win_valid16), 36'd0);

    $display("[TB] 16x16 frame restarted by sof at (3,5)");
    @(posedge clk); #1;
    winCnt[1] = 0;
    for (int k = 0; k < 3*16 + 5; k++) framePixel(1, 8'($urandom_range(0, 255)), (k == 0));
    framePixel(1, 8'($urandom_range(0, 255)), 1'b1);
    checkOutput("restart_fill", 36'(dut16.state), 36'(FILL));
    for (int k = 1; k < 256; k++) framePixel(1, 8'($urandom_range(0, 255)), 1'b0);
    waitIdle(1);
    checkOutput("restart_count", 36'(winCnt[1]), 36'd213);
    checkOutput("restart_sb_empty", 36'(sb16.size()), 36'd0);

    $display("[TB] reset pulse mid-stream on 4x4");
    fixedReady = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    for (int k = 0; k < 11; k++) framePixel(0, 8'(k << 4), (k == 0));
    @(negedge clk);
    checkOutput("pre_rst_win_valid", 36'(win_valid4), 36'd1);
    checkOutput("pre_rst_state", 36'(dut4.state), 36'(STREAM));
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_win_valid", 36'(win_valid4), 36'd0);
    checkOutput("mid_rst_state", 36'(dut4.state), 36'(IDLE));
    checkOutput("mid_rst_pix_ready", 36'(pix_ready4), 36'd1);
    sb4.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    fixedReady = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    sendFrame(0, 0);
    waitIdle(0);
    checkOutput("count4_r", 36'(winCnt[0]), 36'd4);
    checkOutput("first4_r", firstWin[0], FIRST4);
    checkOutput("last4_r", lastWin[0], LAST4);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/conv_window_feeder.md
CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

Interface
REQ-001 SHALL have parameter IMG_W, default 16: pixels per row, legal range 3..1024.
REQ-002 SHALL have parameter IMG_H, default 16: rows per frame, legal range 3..1024.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port pix_in, input, 8: unsigned raster-order input pixel.
REQ-006 SHALL have port pix_valid, input, 1: pix_in and sof are valid.
REQ-007 SHALL have port sof, input, 1: this pixel is frame pixel (0,0).
REQ-008 SHALL have port pix_ready, output, 1: the block accepts a pixel this cycle.
REQ-009 SHALL have port win_out, output, 9x4 packed ([8:0][3:0]): 3x3 window of 4b pixels, row-major, [0]=top-left, [8]=bottom-right.
REQ-010 SHALL have port win_valid, output, 1: win_out holds an unconsumed window.
REQ-011 SHALL have port win_ready, input, 1: the downstream 3x3 convolution consumes the window.

Function
REQ-012 A pixel SHALL be accepted on a cycle with pix_valid && pix_ready; a window SHALL be consumed on a cycle with win_valid && win_ready.
REQ-013 pix_ready SHALL equal (state != DONE) && (!win_valid || win_ready), combinationally.
REQ-014 Each accepted pixel SHALL be quantized to 4b as q = pix_in[7:4] (truncation; see REQ-027).
REQ-015 Two row buffers of IMG_W x 4b SHALL hold rows r-1 and r-2; a 3x3 column shift register SHALL form the window.
REQ-016 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL advance per accepted pixel; col wraps to 0 and row increments at col==IMG_W-1.
REQ-017 The FSM SHALL have states IDLE, FILL, STREAM, DONE; IDLE->FILL on an accepted pixel with sof=1; FILL->STREAM on acceptance of pixel (2,0); STREAM->DONE on acceptance of pixel (IMG_H-1, IMG_W-1); DONE->IDLE once win_valid is low.
REQ-018 In IDLE, pixels with sof=0 SHALL be accepted and discarded.
REQ-019 Accepting pixel (r,c) with r>=2 and c>=2 SHALL load win_out with rows r-2..r, cols c-2..c and set win_valid on the next cycle (latency 1).
REQ-020 win_out SHALL remain stable while win_valid && !win_ready; win_valid SHALL clear after consumption unless a new window is loaded in the same cycle.
REQ-021 A frame SHALL produce exactly (IMG_H-2)*(IMG_W-2) windows; no window SHALL span a row wrap.
REQ-022 sof=1 on an accepted pixel in FILL or STREAM SHALL restart the counters at (0,0) and re-enter FILL; any pending window SHALL still be delivered.

Reset
REQ-023 While rst_n is low: state=IDLE, row=col=0, win_valid=0, win_out=0.
REQ-024 pix_ready SHALL be 1 immediately after reset.
REQ-025 Row-buffer contents need not be reset.
REQ-026 Reset asserted mid-frame SHALL drop any pending window; the block SHALL wait for the next sof.

Configuration
REQ-027 With ROUND_QUANT_EN defined, q SHALL be min(15, (pix_in+8)>>4) (round-to-nearest, saturating); without it, q SHALL be pix_in[7:4].

Structure
REQ-028 Package conv_pkg SHALL hold PIX_W=8, Q_W=4, WIN_N=9, the window typedef (logic [8:0][3:0]) and the FSM state enum, shared with the convolution block.
REQ-029 A sub-module conv_line_buffer (one IMG_W x Q_W delay row) SHALL be instantiated twice.

Verification
REQ-030 4x4 frame, pixels 0x00,0x10,..,0xF0, win_ready=1 -> 4 windows; first = {0,1,2,4,5,6,8,9,10}, last = {5,6,7,9,10,11,13,14,15}.
REQ-031 Same frame, win_ready=0 held 5 cycles after the first window -> win_out stable, pix_ready=0, no window lost or duplicated.
REQ-032 pix_in=0xF8 and 0x18 -> q=15 and 1 without ROUND_QUANT_EN; q=15 (saturated) and 2 with it.
REQ-033 16x16 frame, random pix_valid/win_ready -> exactly 196 windows, then DONE->IDLE; pixels without sof are discarded until the next sof.
REQ-034 sof reasserted at pixel (3,5) of a 16x16 frame -> the pending window is delivered, FILL is re-entered, and the next window corresponds to new pixel (2,2).
REQ-035 rst_n pulsed low mid-STREAM -> win_valid=0 asynchronously, state=IDLE, and a clean 4x4 frame afterwards matches REQ-030.
